// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves GPS 4-bit lookahead groups.
// Optional output saturation on signed overflow is enabled by defining CLA_ADDER_SAT_EN.
module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GPS   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);
   localparam int SW     = 4 * GPS;
   localparam int STAGES = WIDTH / SW;
   localparam int RS     = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int L      = STAGES - 1;

   // Valid/ready: a beat moves on a rising edge when valid & ready are both high.
   // The whole pipe advances as one unit whenever the output register is empty or being drained.
   logic adv;
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv & !rst;

   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic cin);
      logic [SW-1:0] p, g, s;
      logic [3:0]    gp, gg;
      logic          c, c1, c2, c3, c4;
      p = a ^ b;
      g = a & b;
      c = cin;
      s = '0;
      for (int j = 0; j < GPS; j++) begin
         gp = p[4*j +: 4];
         gg = g[4*j +: 4];
         c1 = gg[0] | (gp[0] & c);
         c2 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
         c3 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c);
         c4 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c);
         s[4*j +: 4] = gp ^ {c3, c2, c1, c};
         c = c4;
      end
      return {c, s};
   endfunction

   // Inter-stage registers carry the full operands alongside the partial sum so slices stay aligned.
   logic [WIDTH-1:0] r_a [RS];
   logic [WIDTH-1:0] r_b [RS];
   logic [WIDTH-1:0] r_sum [RS];
   logic             r_c [RS];
   logic             r_v [RS];

   logic [WIDTH-1:0] nx_a [STAGES];
   logic [WIDTH-1:0] nx_b [STAGES];
   logic [WIDTH-1:0] nx_sum [STAGES];
   logic             nx_c [STAGES];
   logic             nx_v [STAGES];

   always_comb begin : comb_stages
      logic [WIDTH-1:0] sa, sb, ss;
      logic             sc, sv;
      logic [SW:0]      res;
      int               pk;
      for (int k = 0; k < STAGES; k++) begin
         pk = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            sa = in_a;
            sb = in_sub ? ~in_b : in_b;
            sc = in_sub ? 1'b1 : in_cin;
            ss = '0;
            sv = in_valid;
         end else begin
            sa = r_a[pk];
            sb = r_b[pk];
            sc = r_c[pk];
            ss = r_sum[pk];
            sv = r_v[pk];
         end
         res                    = cla_slice(sa[k*SW +: SW], sb[k*SW +: SW], sc);
         nx_sum[k]              = ss;
         nx_sum[k][k*SW +: SW]  = res[SW-1:0];
         nx_c[k]                = res[SW];
         nx_a[k]                = sa;
         nx_b[k]                = sb;
         nx_v[k]                = sv;
      end
   end

   logic             ovf_c, zero_c;
   logic [WIDTH-1:0] sum_c;

   always_comb begin
      ovf_c = (nx_a[L][WIDTH-1] == nx_b[L][WIDTH-1]) & (nx_sum[L][WIDTH-1] != nx_a[L][WIDTH-1]);
`ifdef CLA_ADDER_SAT_EN
      sum_c = nx_sum[L];
      // A negative A can only overflow towards the most negative value, and vice versa.
      if (ovf_c)
         sum_c = nx_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      sum_c = nx_sum[L];
`endif
      zero_c = (sum_c == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RS; k++) r_v[k] <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < RS; k++) begin
            r_v[k] <= nx_v[k];
            if (nx_v[k]) begin
               r_a[k]   <= nx_a[k];
               r_b[k]   <= nx_b[k];
               r_sum[k] <= nx_sum[k];
               r_c[k]   <= nx_c[k];
            end
         end
         out_valid <= nx_v[L];
         // Result fields only change when a beat lands, so they hold while out_valid is low.
         if (nx_v[L]) begin
            out_sum  <= sum_c;
            out_cout <= nx_c[L];
            out_ovf  <= ovf_c;
            out_zero <= zero_c;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=16, GPS=2, two-cycle latency).
// Expected sums follow CLA_ADDER_SAT_EN when it is defined for the build.
module tb_pipelined_cla_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [15:0] in_a, in_b;
   logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
   logic [15:0] out_sum;

   pipelined_cla_adder #(.WIDTH(16), .GPS(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] sum;
      logic        cout, ovf, zero;
   } vec_t;

   vec_t        vecs [10];
   int          checks = 0;
   int          failures = 0;
   logic        mon_en = 1'b0;
   logic [18:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic [15:0] sum_wrap, input logic [15:0] sum_sat,
                       input logic cout, input logic ovf, input logic zero_wrap,
                       input logic zero_sat);
      vecs[i].a = a; vecs[i].b = b; vecs[i].cin = cin; vecs[i].sub = sub;
      vecs[i].cout = cout; vecs[i].ovf = ovf;
`ifdef CLA_ADDER_SAT_EN
      vecs[i].sum = sum_sat; vecs[i].zero = zero_sat;
`else
      vecs[i].sum = sum_wrap; vecs[i].zero = zero_wrap;
`endif
   endtask

   task automatic drive(input int i);
      in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_sub = vecs[i].sub;
   endtask

   // Single beat with free-running consumer: checks acceptance, latency and all result fields.
   task automatic apply_vec(input int i);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive(i);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_early_valid", i), out_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_sum", i), out_sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), out_cout, vecs[i].cout);
      check($sformatf("v%0d_ovf", i), out_ovf, vecs[i].ovf);
      check($sformatf("v%0d_zero", i), out_zero, vecs[i].zero);
      @(posedge clk); #1;
   endtask

   // Scoreboard: compare every output transfer against the expected queue.
   always @(negedge clk) begin
      if (mon_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            check("sb_sum", out_sum, e[15:0]);
            check("sb_cout", out_cout, e[18]);
            check("sb_ovf", out_ovf, e[17]);
            check("sb_zero", out_zero, e[16]);
         end
      end
   end

   initial begin
      setv(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      setv(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      setv(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(3, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0);
      setv(4, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(5, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      setv(6, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(7, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
      setv(8, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
      setv(9, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset and idle state
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 16'h0000);
      check("rst_out_flags", {out_cout, out_ovf, out_zero}, 3'b000);
      check("rst_in_ready_after", in_ready, 1);
      @(posedge clk); #1;

      // Table-driven single beats
      for (int i = 0; i < 10; i++) apply_vec(i);

      // Back-to-back push of four beats with a three-cycle consumer stall
      mon_en = 1'b1;
      out_ready = 1'b0;
      fork
         begin
            int idx [4] = '{4, 6, 8, 9};
            for (int j = 0; j < 4; j++) begin
               logic acc;
               acc = 1'b0;
               in_valid = 1'b1;
               drive(idx[j]);
               for (int t = 0; t < 30 && !acc; t++) begin
                  @(negedge clk);
                  acc = in_ready;
                  @(posedge clk); #1;
               end
               if (!acc) check("push_timeout", 0, 1);
               else exp_q.push_back({vecs[idx[j]].cout, vecs[idx[j]].ovf, vecs[idx[j]].zero,
                                     vecs[idx[j]].sum});
            end
            in_valid = 1'b0;
         end
         begin
            logic [15:0] held;
            logic        seen;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
               @(negedge clk);
               seen = out_valid;
            end
            check("stall_out_valid_seen", seen, 1);
            held = out_sum;
            for (int t = 0; t < 3; t++) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 0);
               check("stall_valid_hold", out_valid, 1);
               check("stall_sum_hold", out_sum, held);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check("drain_remaining", exp_q.size(), 0);
      mon_en = 1'b0;

      // Reset with two beats in flight
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(0);
      @(posedge clk); #1;
      drive(1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("flush_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("flush_out_valid", out_valid, 0);
      check("flush_out_sum", out_sum, 16'h0000);
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         check("flush_no_ghost", out_valid, 0);
      end
      @(posedge clk); #1;
      apply_vec(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
